// File: rtl/ws2812b_pixel_feeder_pkg.sv
// ============================================================================
// Module   : ws2812b_pixel_feeder_pkg
// Brief    : Shared constants and types for the WS2812B pixel feeder:
//            register addresses, status bit positions, FIFO entry layout
//            and output FSM states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ws2812b_pixel_feeder_pkg;

    // CPU write addresses
    localparam logic [1:0] ADDR_COLOR  = 2'd0;
    localparam logic [1:0] ADDR_REPEAT = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    // Status byte bit positions
    localparam int STATUS_OVF       = 7;
    localparam int STATUS_BUSY      = 6;
    localparam int STATUS_FULL      = 5;
    localparam int STATUS_EMPTY     = 4;
    localparam int STATUS_PHASE_LSB = 2;
    localparam int STATUS_LEVEL_LSB = 0;

    // FIFO entry layout: {latch, rep[7:0], grb[23:0]}
    localparam int ENTRY_W       = 33;
    localparam int ENTRY_LAT_BIT = 32;
    localparam int ENTRY_REP_LSB = 24;
    localparam int ENTRY_GRB_LSB = 0;

    // Output FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } out_state_e;

endpackage

`default_nettype wire

// File: rtl/ws2812b_pix_fifo.sv
// ============================================================================
// Module   : ws2812b_pix_fifo
// Brief    : Synchronous register-array FIFO for queued pixel entries.
//            Push is ignored when full, pop ignored when empty, flush wins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812b_pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign level   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Storage array: written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ws2812b_pixel_feeder.sv
// ============================================================================
// Module   : ws2812b_pixel_feeder
// Brief    : Assembles CPU byte writes into GRB pixels, queues them with a
//            repeat count and latch mark, and offers them to the WS2812B bit
//            driver over a valid/ready/latch handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812b_pixel_feeder
    import ws2812b_pixel_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  status,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_latch,
    input  logic        pix_ready
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Byte assembler and configuration registers
    logic [1:0] phase_q, phase_d;
    logic [7:0] g_q, g_d;
    logic [7:0] r_q, r_d;
    logic [7:0] rep_q, rep_d;
    logic       latch_pend_q, latch_pend_d;
    logic       ovf_q, ovf_d;

    // Output stage registers
    out_state_e state_q;
    logic [23:0] pix_data_q;
    logic        pix_valid_q;
    logic [7:0]  rem_q;
    logic        lat_q;

    // FIFO interface
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic [LVL_W-1:0]     fifo_level;
    logic [1:0]           level_sat;

    logic wr_clear;
    logic wr_third;

    assign wr_clear  = wr_en & (wr_addr == ADDR_CLEAR);
    assign wr_third  = wr_en & (wr_addr == ADDR_COLOR) & (phase_q == 2'd2);
    assign fifo_push = wr_third & ~fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty & ~wr_clear;
    assign fifo_din  = {latch_pend_q, rep_q, g_q, r_q, wr_data};

    ws2812b_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (wr_clear),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Next-state for the byte assembler, repeat/latch config and overflow flag
    always_comb begin
        phase_d      = phase_q;
        g_d          = g_q;
        r_d          = r_q;
        rep_d        = rep_q;
        latch_pend_d = latch_pend_q;
        ovf_d        = ovf_q;
        if (wr_clear) begin
            phase_d      = 2'd0;
            latch_pend_d = 1'b0;
            ovf_d        = 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_COLOR: begin
                    case (phase_q)
                        2'd0: begin
                            g_d     = wr_data;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            r_d     = wr_data;
                            phase_d = 2'd2;
                        end
                        default: begin
                            // Third byte completes the pixel whether or not it fits
                            phase_d      = 2'd0;
                            latch_pend_d = 1'b0;
                            if (fifo_full) ovf_d = 1'b1;
                        end
                    endcase
                end
                ADDR_REPEAT: rep_d = wr_data;
                ADDR_CTRL: begin
                    if (wr_data[0]) latch_pend_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Assembler and configuration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 2'd0;
            g_q          <= 8'd0;
            r_q          <= 8'd0;
            rep_q        <= 8'd0;
            latch_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            g_q          <= g_d;
            r_q          <= r_d;
            rep_q        <= rep_d;
            latch_pend_q <= latch_pend_d;
            ovf_q        <= ovf_d;
        end
    end

    // Output FSM: load a pixel, offer it, hold data one gap cycle, repeat as asked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pix_data_q  <= 24'd0;
            pix_valid_q <= 1'b0;
            rem_q       <= 8'd0;
            lat_q       <= 1'b0;
        end else if (wr_clear) begin
            // pix_data is left alone; nothing is offered until a new pixel loads
            state_q     <= ST_IDLE;
            pix_valid_q <= 1'b0;
            rem_q       <= 8'd0;
            lat_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pix_data_q  <= fifo_dout[ENTRY_GRB_LSB +: 24];
                        rem_q       <= fifo_dout[ENTRY_REP_LSB +: 8];
                        lat_q       <= fifo_dout[ENTRY_LAT_BIT];
                        pix_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (pix_valid_q && pix_ready) begin
                        pix_valid_q <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (rem_q != 8'd0) begin
                        rem_q       <= rem_q - 8'd1;
                        pix_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign level_sat = (fifo_level > LVL_W'(3)) ? 2'd3 : fifo_level[1:0];

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_latch = lat_q & (rem_q == 8'd0);

    always_comb begin
        status                                 = 8'd0;
        status[STATUS_OVF]                     = ovf_q;
        status[STATUS_BUSY]                    = (state_q != ST_IDLE) | ~fifo_empty;
        status[STATUS_FULL]                    = fifo_full;
        status[STATUS_EMPTY]                   = fifo_empty;
        status[STATUS_PHASE_LSB +: 2]          = phase_q;
        status[STATUS_LEVEL_LSB +: 2]          = level_sat;
    end

endmodule

`default_nettype wire
